// File: rtl/mem_1r1w_banked.sv
// rtl/mem_1r1w_banked.sv - banked 1R1W memory with byte-lane mask, write-first forwarding and range checking.
// Define MEM_OUTPUT_REG_EN to add an output pipeline stage (read latency 2).
module mem_1r1w_banked #(
   parameter int DEPTH       = 48,
   parameter int WIDTH       = 64,
   parameter int BANK_DEPTH  = 32,
   parameter int SLICE_WIDTH = 16,
   parameter int MASK_GRAN   = 8,
   parameter int AW          = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [AW-1:0]              R0_addr,
   input  logic                       R0_en,
   output logic [WIDTH-1:0]           R0_data,
   output logic                       R0_valid,
   input  logic [AW-1:0]              W0_addr,
   input  logic                       W0_en,
   input  logic [WIDTH-1:0]           W0_data,
   input  logic [WIDTH/MASK_GRAN-1:0] W0_mask,
   output logic                       oor_err
);

   localparam int NBANK  = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
   localparam int OFFW   = $clog2(BANK_DEPTH);
   localparam int BKW    = AW - OFFW;
   localparam int NSLICE = WIDTH / SLICE_WIDTH;
   localparam int NLANE  = WIDTH / MASK_GRAN;
   localparam int LPS    = SLICE_WIDTH / MASK_GRAN;
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic            w_rd_inr;
   logic            w_wr_inr;
   logic [BKW-1:0]  w_rd_bank;
   logic [BKW-1:0]  w_wr_bank;
   logic [OFFW-1:0] w_rd_off;
   logic [OFFW-1:0] w_wr_off;
   logic            w_fwd_hit;

   assign w_rd_inr  = ({1'b0, R0_addr} < LP_DEPTH);
   assign w_wr_inr  = ({1'b0, W0_addr} < LP_DEPTH);
   assign w_rd_bank = R0_addr[AW-1:OFFW];
   assign w_wr_bank = W0_addr[AW-1:OFFW];
   assign w_rd_off  = R0_addr[OFFW-1:0];
   assign w_wr_off  = W0_addr[OFFW-1:0];
   assign w_fwd_hit = R0_en & W0_en & w_rd_inr & (R0_addr == W0_addr);

   logic             r_valid;
   logic             r_oor_rd;
   logic             r_fwd;
   logic [BKW-1:0]   r_bank;
   logic [WIDTH-1:0] r_fwd_data;
   logic [NLANE-1:0] r_fwd_mask;
   logic             r_oor_err;

   // Read-side context is only captured on R0_en so the output mux holds its last result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_oor_rd   <= 1'b0;
         r_fwd      <= 1'b0;
         r_bank     <= '0;
         r_fwd_data <= '0;
         r_fwd_mask <= '0;
         r_oor_err  <= 1'b0;
      end else begin
         r_valid <= R0_en;
         if (R0_en) begin
            r_bank   <= w_rd_bank;
            r_oor_rd <= ~w_rd_inr;
            r_fwd    <= w_fwd_hit;
            if (w_fwd_hit) begin
               r_fwd_data <= W0_data;
               r_fwd_mask <= W0_mask;
            end
         end
         if ((R0_en && !w_rd_inr) || (W0_en && !w_wr_inr))
            r_oor_err <= 1'b1;
      end
   end

   logic [NBANK-1:0][WIDTH-1:0] w_bank_rdata;

   for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
      logic w_rd_sel;
      logic w_wr_sel;
      assign w_rd_sel = R0_en & w_rd_inr & (w_rd_bank == BKW'(gb));
      assign w_wr_sel = W0_en & w_wr_inr & (w_wr_bank == BKW'(gb));

      for (genvar gs = 0; gs < NSLICE; gs++) begin : g_slice
         logic [SLICE_WIDTH-1:0] r_mem [BANK_DEPTH];
         logic [SLICE_WIDTH-1:0] r_rd;

         always_ff @(posedge clock) begin
            if (w_wr_sel) begin
               for (int l = 0; l < LPS; l++) begin
                  if (W0_mask[gs*LPS + l])
                     r_mem[w_wr_off][l*MASK_GRAN +: MASK_GRAN] <=
                        W0_data[gs*SLICE_WIDTH + l*MASK_GRAN +: MASK_GRAN];
               end
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset)
               r_rd <= '0;
            else if (w_rd_sel)
               r_rd <= r_mem[w_rd_off];
         end

         assign w_bank_rdata[gb][gs*SLICE_WIDTH +: SLICE_WIDTH] = r_rd;
      end
   end

   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_mexp;
   logic [WIDTH-1:0] w_stage1;

   // Array read returns pre-write data; forwarded lanes are merged here for write-first.
   always_comb begin
      w_raw = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (r_bank == BKW'(b))
            w_raw = w_bank_rdata[b];
      end
      w_mexp = '0;
      for (int i = 0; i < NLANE; i++)
         w_mexp[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{r_fwd_mask[i]}};
      if (r_oor_rd)
         w_stage1 = '0;
      else if (r_fwd)
         w_stage1 = (w_mexp & r_fwd_data) | (~w_mexp & w_raw);
      else
         w_stage1 = w_raw;
   end

`ifdef MEM_OUTPUT_REG_EN
   logic [WIDTH-1:0] r_data_q;
   logic             r_valid_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= r_valid;
         if (r_valid)
            r_data_q <= w_stage1;
      end
   end

   assign R0_data  = r_data_q;
   assign R0_valid = r_valid_q;
`else
   assign R0_data  = w_stage1;
   assign R0_valid = r_valid;
`endif

   assign oor_err = r_oor_err;

endmodule

// File: tb/tb_mem_1r1w_banked.sv
// tb/tb_mem_1r1w_banked.sv - self-checking bench for mem_1r1w_banked against a word-level memory model.
// Honours MEM_OUTPUT_REG_EN (read latency 2 when defined).
module tb_mem_1r1w_banked;

`ifdef MEM_OUTPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DEPTH = 48;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  R0_addr = '0;
   logic        R0_en = 1'b0;
   logic [63:0] R0_data;
   logic        R0_valid;
   logic [5:0]  W0_addr = '0;
   logic        W0_en = 1'b0;
   logic [63:0] W0_data = '0;
   logic [7:0]  W0_mask = '0;
   logic        oor_err;

   mem_1r1w_banked dut (
      .clock    (clock),
      .reset    (reset),
      .R0_addr  (R0_addr),
      .R0_en    (R0_en),
      .R0_data  (R0_data),
      .R0_valid (R0_valid),
      .W0_addr  (W0_addr),
      .W0_en    (W0_en),
      .W0_data  (W0_data),
      .W0_mask  (W0_mask),
      .oor_err  (oor_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [63:0] m_mem [DEPTH];
   logic [63:0] m_out_data  = '0;
   logic        m_out_valid = 1'b0;
   logic [63:0] m_s1_data   = '0;
   logic        m_s1_valid  = 1'b0;
   logic        m_oor       = 1'b0;

   logic [63:0] obs_data  [8192];
   logic        obs_valid [8192];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                         input logic [7:0] mask);
      logic [63:0] r;
      r = old_w;
      for (int i = 0; i < 8; i++)
         if (mask[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   task automatic drive(input logic re, input logic [5:0] ra, input logic we, input logic [5:0] wa,
                        input logic [63:0] wd, input logic [7:0] wm);
      R0_en   = re;
      R0_addr = ra;
      W0_en   = we;
      W0_addr = wa;
      W0_data = wd;
      W0_mask = wm;
   endtask

   // One clock: advance the model from the inputs seen at the edge, then compare the DUT.
   task automatic cycle();
      logic        t_v;
      logic [63:0] t_d;
      @(posedge clock);
      t_v = R0_en;
      t_d = 64'h0;
      if (R0_en && R0_addr < DEPTH) begin
         t_d = m_mem[R0_addr];
         if (W0_en && W0_addr == R0_addr) t_d = merge(t_d, W0_data, W0_mask);
      end
      if ((R0_en && R0_addr >= DEPTH) || (W0_en && W0_addr >= DEPTH)) m_oor = 1'b1;
      if (W0_en && W0_addr < DEPTH) m_mem[W0_addr] = merge(m_mem[W0_addr], W0_data, W0_mask);
      if (LAT == 2) begin
         if (m_s1_valid) m_out_data = m_s1_data;
         m_out_valid = m_s1_valid;
         m_s1_valid  = t_v;
         m_s1_data   = t_d;
      end else begin
         m_out_valid = t_v;
         if (t_v) m_out_data = t_d;
      end
      #1;
      chk("r0_valid", {63'b0, R0_valid}, {63'b0, m_out_valid});
      chk("r0_data", R0_data, m_out_data);
      chk("oor_err", {63'b0, oor_err}, {63'b0, m_oor});
      obs_data[cyc]  = R0_data;
      obs_valid[cyc] = R0_valid;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 8'h00);
         cycle();
      end
   endtask

   task automatic model_reset();
      m_out_data  = '0;
      m_out_valid = 1'b0;
      m_s1_data   = '0;
      m_s1_valid  = 1'b0;
      m_oor       = 1'b0;
   endtask

   initial begin
      int t;
      logic [5:0]  ra;
      logic [5:0]  wa;
      logic [63:0] wd;
      logic [7:0]  wm;

      #1 reset = 1'b1;
      #2;
      chk("rst_valid", {63'b0, R0_valid}, 64'h0);
      chk("rst_data", R0_data, 64'h0);
      chk("rst_oor", {63'b0, oor_err}, 64'h0);
      @(posedge clock);
      #2 reset = 1'b0;

      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 6'd0, 1'b1, 6'(a), {$urandom, $urandom}, 8'hFF);
         cycle();
      end

      drive(1'b0, 6'd0, 1'b1, 6'd5, 64'h0123456789ABCDEF, 8'hFF);
      cycle();
      drive(1'b1, 6'd5, 1'b0, 6'd0, 64'h0, 8'h00);
      t = cyc;
      cycle();
      idle(LAT);
      chk("t1_data", obs_data[t+LAT-1], 64'h0123456789ABCDEF);
      chk("t1_valid", {63'b0, obs_valid[t+LAT-1]}, 64'h1);

      drive(1'b0, 6'd0, 1'b1, 6'd31, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      cycle();
      drive(1'b0, 6'd0, 1'b1, 6'd32, 64'h5555555555555555, 8'hFF);
      cycle();
      drive(1'b1, 6'd31, 1'b0, 6'd0, 64'h0, 8'h00);
      t = cyc;
      cycle();
      drive(1'b1, 6'd32, 1'b0, 6'd0, 64'h0, 8'h00);
      cycle();
      idle(LAT);
      chk("t2_bank0", obs_data[t+LAT-1], 64'hAAAAAAAAAAAAAAAA);
      chk("t2_bank1", obs_data[t+LAT], 64'h5555555555555555);

      drive(1'b0, 6'd0, 1'b1, 6'd7, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      cycle();
      drive(1'b0, 6'd0, 1'b1, 6'd7, 64'h0, 8'h0F);
      cycle();
      drive(1'b1, 6'd7, 1'b0, 6'd0, 64'h0, 8'h00);
      t = cyc;
      cycle();
      idle(LAT);
      chk("t3_mask", obs_data[t+LAT-1], 64'hFFFFFFFF00000000);

      drive(1'b0, 6'd0, 1'b1, 6'd10, 64'h1111111111111111, 8'hFF);
      cycle();
      drive(1'b1, 6'd10, 1'b1, 6'd10, 64'h2222222222222222, 8'hF0);
      t = cyc;
      cycle();
      idle(LAT);
      chk("t4_fwd", obs_data[t+LAT-1], 64'h2222222211111111);

      drive(1'b1, 6'd50, 1'b0, 6'd0, 64'h0, 8'h00);
      t = cyc;
      cycle();
      chk("t5_oor_set", {63'b0, oor_err}, 64'h1);
      idle(LAT);
      chk("t5_oor_data", obs_data[t+LAT-1], 64'h0);
      chk("t5_oor_valid", {63'b0, obs_valid[t+LAT-1]}, 64'h1);
      drive(1'b0, 6'd0, 1'b1, 6'd60, 64'hDEADBEEFDEADBEEF, 8'hFF);
      cycle();
      idle(2);
      chk("t5_oor_sticky", {63'b0, oor_err}, 64'h1);

      drive(1'b1, 6'd5, 1'b0, 6'd0, 64'h0, 8'h00);
      cycle();
      drive(1'b0, 6'd0, 1'b0, 6'd0, 64'h0, 8'h00);
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_valid", {63'b0, R0_valid}, 64'h0);
      chk("t6_rst_data", R0_data, 64'h0);
      chk("t6_rst_oor", {63'b0, oor_err}, 64'h0);
      model_reset();
      @(posedge clock);
      #2 reset = 1'b0;
      drive(1'b1, 6'd5, 1'b0, 6'd0, 64'h0, 8'h00);
      t = cyc;
      cycle();
      idle(LAT + 3);
      chk("t6_readback", obs_data[t+LAT-1], 64'h0123456789ABCDEF);
      chk("t6_hold_data", R0_data, 64'h0123456789ABCDEF);
      chk("t6_hold_valid", {63'b0, R0_valid}, 64'h0);

      for (int n = 0; n < 1500; n++) begin
         ra = ($urandom % 8 == 0) ? 6'($urandom % 64) : 6'($urandom % DEPTH);
         wa = ($urandom % 4 == 0) ? ra :
              (($urandom % 8 == 0) ? 6'($urandom % 64) : 6'($urandom % DEPTH));
         wd = {$urandom, $urandom};
         wm = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
         drive(1'($urandom), ra, 1'($urandom), wa, wd, wm);
         cycle();
      end

      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b1, 6'(a), 1'b0, 6'd0, 64'h0, 8'h00);
         cycle();
      end
      idle(LAT + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
